// File: rtl/prog_loader_pkg.sv
// Shared constants and state encodings for the serial program loader.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         PROG_DEPTH = 16;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LOAD      = 2'd1,
        CSUM      = 2'd2,
        DONE      = 2'd3
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/prog_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling every DIV cycles, framing check.
// byte_vld_o pulses one cycle after the stop-bit sample; no backpressure, bytes are never held.
module prog_uart_rx
    import prog_loader_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       clk_i,
    input  logic       clr_n_i,
    input  logic       rxd_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_dat_o,
    output logic       frame_err_o
);

    localparam int                CNT_W   = $clog2(DIV);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sr_q, sr_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;
    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sr_d    = sr_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at half a bit was a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sr_d  = {rxd_sync_q, sr_q[7:1]};
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    vld_d   = rxd_sync_q;
                    ferr_d  = !rxd_sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            sr_q       <= '0;
            vld_q      <= 1'b0;
            ferr_q     <= 1'b0;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            sr_q       <= sr_d;
            vld_q      <= vld_d;
            ferr_q     <= ferr_d;
            rxd_meta_q <= rxd_i;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    assign byte_vld_o  = vld_q;
    assign byte_dat_o  = sr_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a 16-byte program over UART after a 0xA5 sync; cpu_run releases the CPU once complete.
// Zero-latency reads; no backpressure. Checksum stage present only with PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       CLK,
    input  logic       clr_n,
    input  logic       rxd,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cpu_run,
    output logic       busy,
    output logic       err
);

    localparam int         DIV       = CLK_HZ / BAUD;
    localparam logic [3:0] LAST_ADDR = 4'(PROG_DEPTH - 1);

    logic       byte_vld;
    logic       frame_err;
    logic [7:0] byte_dat;
    logic       is_sync;
    logic       wr_en;

    ld_state_t  state_q, state_d;
    logic [3:0] wr_ptr_q, wr_ptr_d;
    logic       err_q, err_d;
    logic [7:0] mem_q [PROG_DEPTH];
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
`endif

    prog_uart_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk_i       (CLK),
        .clr_n_i     (clr_n),
        .rxd_i       (rxd),
        .byte_vld_o  (byte_vld),
        .byte_dat_o  (byte_dat),
        .frame_err_o (frame_err)
    );

    assign is_sync = byte_vld && (byte_dat == SYNC_BYTE);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        err_d    = err_q;
        wr_en    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            // DONE only reacts to a resync, exactly like WAIT_SYNC.
            WAIT_SYNC, DONE: begin
                if (is_sync) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                    err_d    = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d    = '0;
`endif
                end
            end
            LOAD: begin
                if (byte_vld) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d    = sum_q + byte_dat;
                    if (wr_ptr_q == LAST_ADDR) state_d = CSUM;
`else
                    if (wr_ptr_q == LAST_ADDR) state_d = DONE;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CSUM: begin
                if (byte_vld) begin
                    if (byte_dat == sum_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = WAIT_SYNC;
                    end
                end
            end
`endif
            default: state_d = WAIT_SYNC;
        endcase
        if (frame_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!clr_n) begin
            state_q  <= WAIT_SYNC;
            wr_ptr_q <= '0;
            err_q    <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
            for (int i = 0; i < PROG_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
            if (wr_en) begin
                mem_q[wr_ptr_q] <= byte_dat;
            end
        end
    end

    assign rd_data = mem_q[rd_addr];
    assign busy    = (state_q == LOAD) || (state_q == CSUM);
    // A resync in DONE must hold the CPU off in the very cycle it is seen.
    assign cpu_run = (state_q == DONE) && !is_sync;
    assign err     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader at CLK_HZ=16, BAUD=1 (16 clocks per bit).
module tb_prog_loader;

    localparam int DIVB = 16;

    logic       CLK = 1'b0;
    logic       clr_n;
    logic       rxd;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       cpu_run;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_pass   = 0;
    int vld_cyc;
    int rise_cyc;
    logic run_at_vld;

    prog_loader #(.CLK_HZ(16), .BAUD(1)) dut (
        .CLK     (CLK),
        .clr_n   (clr_n),
        .rxd     (rxd),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .cpu_run (cpu_run),
        .busy    (busy),
        .err     (err)
    );

    always #5 CLK = ~CLK;

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        logic       prev_run;
        frame      = {stop_bit, b, 1'b0};
        vld_cyc    = -1;
        rise_cyc   = -1;
        run_at_vld = 1'bx;
        prev_run   = cpu_run;
        for (int i = 0; i < 10 * DIVB + 8; i++) begin
            rxd = (i < 10 * DIVB) ? frame[i / DIVB] : 1'b1;
            @(negedge CLK);
            if (dut.byte_vld && vld_cyc < 0) begin
                vld_cyc    = i;
                run_at_vld = cpu_run;
            end
            if (cpu_run && !prev_run && rise_cyc < 0) rise_cyc = i;
            prev_run = cpu_run;
            @(posedge CLK);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        clr_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge CLK);
        clr_n = 1'b1;
        @(negedge CLK);
    endtask

    task automatic check_mem(input string name, input int addr, input logic [7:0] exp);
        rd_addr = 4'(addr);
        #1;
        n_checks++;
        if (rd_data !== exp) $display("FAIL %s mem[%0d]: got %h expected %h", name, addr, rd_data, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (cpu_run !== 1'b0) $display("FAIL reset_cpu_run: got %b expected 0", cpu_run); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
        check_mem("reset", 0, 8'h00);
        check_mem("reset", 15, 8'h00);
    endtask

    task automatic test_no_sync();
        send_byte(8'h55, 1'b1);
        send_byte(8'h12, 1'b1);
        n_checks++; if (busy !== 1'b0) $display("FAIL nosync_busy: got %b expected 0", busy); else n_pass++;
        for (int i = 0; i < 16; i++) check_mem("nosync", i, 8'h00);
    endtask

    task automatic test_load_ok();
        send_byte(8'hA5, 1'b1);
        n_checks++; if (busy !== 1'b1) $display("FAIL load_busy: got %b expected 1", busy); else n_pass++;
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
        n_checks++; if (cpu_run !== 1'b0) $display("FAIL load_run_before_csum: got %b expected 0", cpu_run); else n_pass++;
        send_byte(8'h78, 1'b1);
`endif
        n_checks++;
        if (vld_cyc < 0 || rise_cyc != vld_cyc + 1)
            $display("FAIL load_run_timing: got rise at %0d expected %0d", rise_cyc, vld_cyc + 1);
        else n_pass++;
        for (int i = 0; i < 16; i++) check_mem("load", i, 8'(i));
        check_mem("load_rd5", 5, 8'h05);
        n_checks++; if (cpu_run !== 1'b1) $display("FAIL load_cpu_run: got %b expected 1", cpu_run); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL load_busy_done: got %b expected 0", busy); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL load_err: got %b expected 0", err); else n_pass++;
    endtask

    task automatic test_done_resync();
        send_byte(8'hA5, 1'b1);
        n_checks++; if (run_at_vld !== 1'b0) $display("FAIL resync_run_same_cycle: got %b expected 0", run_at_vld); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL resync_busy: got %b expected 1", busy); else n_pass++;
        n_checks++; if (cpu_run !== 1'b0) $display("FAIL resync_cpu_run: got %b expected 0", cpu_run); else n_pass++;
        for (int i = 0; i < 16; i++) send_byte(8'hFF, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'hF0, 1'b1);
`endif
        n_checks++; if (cpu_run !== 1'b1) $display("FAIL reload_cpu_run: got %b expected 1", cpu_run); else n_pass++;
        check_mem("reload", 3, 8'hFF);
        check_mem("reload", 15, 8'hFF);
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        do_reset();
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h77, 1'b1);
        n_checks++; if (err !== 1'b1) $display("FAIL badcsum_err: got %b expected 1", err); else n_pass++;
        n_checks++; if (cpu_run !== 1'b0) $display("FAIL badcsum_cpu_run: got %b expected 0", cpu_run); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL badcsum_busy: got %b expected 0", busy); else n_pass++;
        // In WAIT_SYNC a plain byte must be ignored, not written.
        send_byte(8'h3C, 1'b1);
        check_mem("badcsum", 0, 8'h00);
        n_checks++; if (busy !== 1'b0) $display("FAIL badcsum_still_idle: got %b expected 0", busy); else n_pass++;
    endtask
`endif

    task automatic test_framing();
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        n_checks++; if (err !== 1'b1) $display("FAIL frame_err: got %b expected 1", err); else n_pass++;
        check_mem("frame_not_written", 3, 8'h00);
        send_byte(8'h5A, 1'b1);
        check_mem("frame_ptr_kept", 3, 8'h5A);
        check_mem("frame_next_empty", 4, 8'h00);
        check_mem("frame_prev", 2, 8'h33);
    endtask

    task automatic test_reset_midload();
        do_reset();
        send_byte(8'hA5, 1'b1);
        for (int i = 1; i <= 7; i++) send_byte(8'(i), 1'b1);
        check_mem("midload_pre", 6, 8'h07);
        n_checks++; if (busy !== 1'b1) $display("FAIL midload_busy_pre: got %b expected 1", busy); else n_pass++;
        @(posedge CLK);
        clr_n = 1'b0;
        @(posedge CLK);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL midload_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (cpu_run !== 1'b0) $display("FAIL midload_cpu_run: got %b expected 0", cpu_run); else n_pass++;
        for (int i = 0; i < 16; i++) check_mem("midload", i, 8'h00);
        clr_n = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        clr_n   = 1'b0;
        rxd     = 1'b1;
        rd_addr = 4'd0;
        test_reset();
        test_no_sync();
        test_load_ok();
        test_done_resync();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_framing();
        test_reset_midload();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
